// File: rtl/ins_cache.sv
// Direct-mapped, read-only instruction cache: 8 blocks x 16 bytes over a 1 KB space.
// A miss stalls the fetch stage while one block is read from instruction memory.
module ins_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT_INS,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     valid_q, valid_d;
  logic [2:0]     tag_q [8];
  logic [127:0]   data_q [8];
  logic [2:0]     lat_tag_q, lat_tag_d;
  logic [2:0]     lat_idx_q, lat_idx_d;
  logic [1:0]     lat_off_q, lat_off_d;
  logic [127:0]   fill_q, fill_d;
  logic           mem_read_q, mem_read_d;
  logic [5:0]     mem_address_q, mem_address_d;
  logic           wr_en;

  logic           req;
  logic           hit;
  logic [2:0]     pc_tag;
  logic [2:0]     pc_idx;
  logic [1:0]     pc_off;

  function automatic logic [31:0] sel_word(input logic [127:0] blk, input logic [1:0] off);
    return blk[{off, 5'b0} +: 32];
  endfunction

  // The all-ones-minus-four post-reset PC means "no fetch yet"
  assign req    = (PC != 32'hFFFF_FFFC);
  assign pc_tag = PC[9:7];
  assign pc_idx = PC[6:4];
  assign pc_off = PC[3:2];
  assign hit    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    lat_tag_d     = lat_tag_q;
    lat_idx_d     = lat_idx_q;
    lat_off_d     = lat_off_q;
    fill_d        = fill_q;
    mem_read_d    = 1'b0;
    mem_address_d = mem_address_q;
    wr_en         = 1'b0;
    BUSYWAIT_INS  = 1'b0;
    INSTRUCTION   = 32'h0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          INSTRUCTION = sel_word(data_q[pc_idx], pc_off);
        end else if (req) begin
          BUSYWAIT_INS  = 1'b1;
          state_d       = MEM_READ;
          lat_tag_d     = pc_tag;
          lat_idx_d     = pc_idx;
          lat_off_d     = pc_off;
          mem_read_d    = 1'b1;
          mem_address_d = {pc_tag, pc_idx};
        end
      end
      MEM_READ: begin
        BUSYWAIT_INS = 1'b1;
        mem_read_d   = mem_busywait;
        if (!mem_busywait) begin
          state_d = UPDATE;
          fill_d  = mem_readdata;
        end
      end
      UPDATE: begin
        BUSYWAIT_INS       = 1'b1;
        INSTRUCTION        = sel_word(fill_q, lat_off_q);
        wr_en              = 1'b1;
        valid_d[lat_idx_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the stall and fetch outputs without waiting for a clock
    if (RESET) begin
      BUSYWAIT_INS = 1'b0;
      INSTRUCTION  = 32'h0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      valid_q       <= 8'h0;
      lat_tag_q     <= 3'h0;
      lat_idx_q     <= 3'h0;
      lat_off_q     <= 2'h0;
      mem_read_q    <= 1'b0;
      mem_address_q <= 6'h0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      lat_tag_q     <= lat_tag_d;
      lat_idx_q     <= lat_idx_d;
      lat_off_q     <= lat_off_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
    if (wr_en) begin
      data_q[lat_idx_q] <= fill_q;
      tag_q[lat_idx_q]  <= lat_tag_q;
    end
  end

endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache: a timeline model of hits/misses checked every cycle,
// plus hand-computed expectations for the reset, hit, eviction and redirect scenarios.
module tb_ins_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT_INS;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 5;
  int mem_cnt  = 0;
  logic [5:0] seen_addr[$];

  ins_cache dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT_INS(BUSYWAIT_INS), .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return {20'hABCDE, pc[9:4], 4'h0, pc[3:2]};
  endfunction

  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = {20'hABCDE, a, 4'h0, i[1:0]};
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: busy for lat-1 cycles of a request, block valid in the last one
  always @(posedge CLK) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
  always @(negedge CLK) begin
    mem_busywait = mem_read && (mem_cnt < lat - 1);
    mem_readdata = blk(mem_address);
  end

  // Behavioural model: cache contents plus the number of stall cycles still owed
  bit         m_valid [8];
  logic [2:0] m_tag   [8];
  int         stall_left = 0;
  logic [2:0] f_idx, f_tag;

  always @(negedge CLK) begin
    if (RESET) begin
      chk("m_rst_busy", 32'(BUSYWAIT_INS), 32'h0);
      chk("m_rst_mread", 32'(mem_read), 32'h0);
      chk("m_rst_maddr", 32'(mem_address), 32'h0);
      chk("m_rst_instr", INSTRUCTION, 32'h0);
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      stall_left = 0;
    end else if (stall_left == 0) begin
      chk("m_idle_mread", 32'(mem_read), 32'h0);
      if (PC == 32'hFFFF_FFFC) begin
        chk("m_noreq_busy", 32'(BUSYWAIT_INS), 32'h0);
        chk("m_noreq_instr", INSTRUCTION, 32'h0);
      end else if (m_valid[PC[6:4]] && m_tag[PC[6:4]] == PC[9:7]) begin
        chk("m_hit_busy", 32'(BUSYWAIT_INS), 32'h0);
        chk("m_hit_instr", INSTRUCTION, exp_word(PC));
      end else begin
        chk("m_miss_busy", 32'(BUSYWAIT_INS), 32'h1);
        stall_left = lat + 1;
        f_idx = PC[6:4];
        f_tag = PC[9:7];
      end
    end else begin
      chk("m_stall_busy", 32'(BUSYWAIT_INS), 32'h1);
      chk("m_stall_mread", 32'(mem_read), (stall_left > 1) ? 32'h1 : 32'h0);
      if (stall_left > 1) chk("m_stall_maddr", 32'(mem_address), 32'({f_tag, f_idx}));
      stall_left--;
      if (stall_left == 0) begin
        m_valid[f_idx] = 1'b1;
        m_tag[f_idx]   = f_tag;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Counts stall cycles until the fetch proceeds; records each new memory request address
  task automatic wait_idle(output int busy_n, output int rd_n);
    logic prev;
    busy_n = 0;
    rd_n   = 0;
    prev   = 1'b0;
    seen_addr.delete();
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT_INS) break;
      busy_n++;
      if (mem_read) rd_n++;
      if (mem_read && !prev) seen_addr.push_back(mem_address);
      prev = mem_read;
      if (busy_n > 200) begin
        chk("stall_timeout", 32'(busy_n), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    int bn, rn;
    RESET = 1'b1;
    PC = 32'hFFFF_FFFC;
    mem_busywait = 1'b0;
    mem_readdata = '0;
    repeat (2) cyc();
    // A real address during reset must still produce no stall
    PC = 32'h0;
    @(negedge CLK);
    chk("rst_busy_with_pc", 32'(BUSYWAIT_INS), 32'h0);
    chk("rst_mread", 32'(mem_read), 32'h0);
    chk("rst_instr", INSTRUCTION, 32'h0);
    cyc();
    PC = 32'hFFFF_FFFC;
    RESET = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("noreq_busy", 32'(BUSYWAIT_INS), 32'h0);
      chk("noreq_mread", 32'(mem_read), 32'h0);
      cyc();
    end

    // Cold miss on 0x000
    PC = 32'h000;
    @(negedge CLK);
    chk("miss_busy_immediate", 32'(BUSYWAIT_INS), 32'h1);
    chk("miss_mread_not_yet", 32'(mem_read), 32'h0);
    wait_idle(bn, rn);
    chk("cold_stall_cycles", 32'(bn + 1), 32'd7);
    chk("cold_mread_cycles", 32'(rn), 32'd5);
    chk("cold_req_count", 32'(seen_addr.size()), 32'd1);
    if (seen_addr.size() > 0) chk("cold_maddr", 32'(seen_addr[0]), 32'h00);
    chk("cold_instr", INSTRUCTION, 32'hABCDE000);

    // Hits on the rest of block 0
    for (int w = 1; w < 4; w++) begin
      cyc();
      PC = 32'(w * 4);
      @(negedge CLK);
      chk("hit_busy", 32'(BUSYWAIT_INS), 32'h0);
      chk("hit_mread", 32'(mem_read), 32'h0);
      chk("hit_instr", INSTRUCTION, 32'hABCDE000 | 32'(w));
    end

    // Conflict miss on index 0, then 0x000 must miss again
    cyc();
    PC = 32'h080;
    wait_idle(bn, rn);
    chk("conflict_stall", 32'(bn), 32'd7);
    if (seen_addr.size() > 0) chk("conflict_maddr", 32'(seen_addr[0]), 32'h08);
    chk("conflict_instr", INSTRUCTION, 32'hABCDE200);
    cyc();
    PC = 32'h000;
    wait_idle(bn, rn);
    chk("evicted_stall", 32'(bn), 32'd7);
    chk("evicted_instr", INSTRUCTION, 32'hABCDE000);

    // Single-cycle memory latency
    cyc();
    lat = 1;
    PC = 32'h040;
    wait_idle(bn, rn);
    chk("lat1_stall", 32'(bn), 32'd3);
    chk("lat1_mread_cycles", 32'(rn), 32'd1);
    chk("lat1_instr", INSTRUCTION, 32'hABCDE100);
    cyc();
    lat = 5;

    // Reset in the third MEM_READ cycle aborts the fill
    PC = 32'h0C0;
    repeat (3) @(posedge CLK);
    #1;
    chk("pre_abort_mread", 32'(mem_read), 32'h1);
    chk("pre_abort_maddr", 32'(mem_address), 32'h0C);
    #1;
    RESET = 1'b1;
    #1;
    chk("abort_mread", 32'(mem_read), 32'h0);
    chk("abort_busy", 32'(BUSYWAIT_INS), 32'h0);
    chk("abort_instr", INSTRUCTION, 32'h0);
    cyc();
    PC = 32'h000;
    RESET = 1'b0;
    wait_idle(bn, rn);
    chk("post_reset_stall", 32'(bn), 32'd7);
    chk("post_reset_instr", INSTRUCTION, 32'hABCDE000);

    // PC moves mid-fill: index 1 is filled, then 0x020 misses on its own
    cyc();
    PC = 32'h010;
    cyc();
    cyc();
    PC = 32'h020;
    wait_idle(bn, rn);
    chk("redirect_req_count", 32'(seen_addr.size()), 32'd2);
    if (seen_addr.size() == 2) begin
      chk("redirect_first_maddr", 32'(seen_addr[0]), 32'h01);
      chk("redirect_second_maddr", 32'(seen_addr[1]), 32'h02);
    end
    chk("redirect_instr", INSTRUCTION, 32'hABCDE080);
    cyc();
    PC = 32'h014;
    @(negedge CLK);
    chk("redirect_idx1_hit_busy", 32'(BUSYWAIT_INS), 32'h0);
    chk("redirect_idx1_hit_instr", INSTRUCTION, 32'hABCDE041);

    cyc();
    PC = 32'hFFFF_FFFC;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ins_cache.md
INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 blocks x 16 bytes, direct-mapped, covering a 1 KB instruction space.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- CLK  in  1  single system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  32  fetch address from the program counter.
- INSTRUCTION  out  32  fetched instruction word.
- BUSYWAIT_INS  out  1  stall request to the program counter and pipeline.
- mem_read  out  1  block-read request to instruction memory.
- mem_address  out  6  block address, {tag, index}.
- mem_readdata  in  128  16-byte block returned by memory; word 0 is in bits [31:0].
- mem_busywait  in  1  memory busy; a block is valid in the cycle it deasserts.

Function
REQ-003 Address split SHALL use PC[9:7] as tag, PC[6:4] as index, PC[3:2] as word offset; PC[1:0] and PC[31:10] SHALL be ignored.
REQ-004 PC = 32'hFFFF_FFFC (post-reset value) SHALL be treated as no request: BUSYWAIT_INS = 0, no memory traffic, INSTRUCTION = 0.
REQ-005 Per block, the block SHALL store: a valid bit, a 3-bit tag and a 128-bit data word.
REQ-006 Hit SHALL be evaluated combinationally: hit = valid[index] && (tag[index] == PC[9:7]).
REQ-007 On a hit in IDLE, INSTRUCTION SHALL be the selected word of data[index] in the same cycle, with BUSYWAIT_INS = 0.
REQ-008 The FSM SHALL have exactly three states: IDLE, MEM_READ, UPDATE.
REQ-009 IDLE -> MEM_READ on the posedge where a request misses; BUSYWAIT_INS SHALL assert combinationally in that same cycle.
REQ-010 On the miss edge, the block SHALL latch the request tag, index and offset; all fill and output activity SHALL use the latched values.
REQ-011 In MEM_READ, the block SHALL drive mem_read = 1 and mem_address = {latched tag, latched index}, and hold BUSYWAIT_INS = 1.
REQ-012 MEM_READ SHALL remain while mem_busywait = 1, and SHALL go to UPDATE on the first posedge with mem_busywait = 0, capturing mem_readdata.
REQ-013 In UPDATE, the block SHALL drive mem_read = 0 and BUSYWAIT_INS = 1, and on the posedge write data, tag and valid = 1 for the latched index, then go to IDLE.
REQ-014 After UPDATE, IDLE SHALL re-evaluate the hit, which must now succeed; miss penalty = (memory latency cycles) + 2 stall cycles.
REQ-015 Conflict miss: a valid block with a different tag SHALL be overwritten without writeback (read-only cache).
REQ-016 A PC change while in MEM_READ/UPDATE SHALL NOT redirect the fill; after return to IDLE the current PC is evaluated afresh.
REQ-017 mem_read SHALL never be asserted outside MEM_READ; at most one outstanding memory request SHALL exist at any time.
REQ-018 The block SHALL contain no combinational loop from BUSYWAIT_INS to PC within the block.

Reset
REQ-019 While RESET = 1, the block SHALL force: state = IDLE, all valid bits = 0, mem_read = 0, mem_address = 0, BUSYWAIT_INS = 0, INSTRUCTION = 0; tags and data are don't-care.
REQ-020 RESET asserting in MEM_READ or UPDATE SHALL abort the fill immediately (asynchronous) and leave no block valid.
REQ-021 After RESET falls, the first request SHALL miss regardless of index.

Verification
REQ-022 Reset, then PC = 0x000, memory latency 5 -> BUSYWAIT_INS = 1 immediately; mem_read = 1 with mem_address = 6'h00 for 5 cycles; then UPDATE; BUSYWAIT_INS = 0 in cycle 7; INSTRUCTION = word 0.
REQ-023 PC = 0x004, 0x008, 0x00C after REQ-022 -> three consecutive hits, BUSYWAIT_INS = 0 throughout, words 1..3 returned, mem_read stays 0.
REQ-024 PC = 0x080 (same index 0, tag 1) -> miss, mem_address = 6'h08; then PC = 0x000 -> miss again (eviction confirmed).
REQ-025 RESET pulsed in the 3rd MEM_READ cycle -> mem_read = 0 and BUSYWAIT_INS = 0 the same instant; re-request of PC = 0x000 misses.
REQ-026 PC = 0xFFFF_FFFC held 4 cycles -> BUSYWAIT_INS = 0 and mem_read = 0 throughout.
REQ-027 PC changed from 0x010 to 0x020 mid-MEM_READ -> block index 1 filled; IDLE then misses on 0x020 (index 2).
